// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result buffer: entry layout and
// default buffer depth.
package alu_pkg;

    localparam int ALU_RES_W     = 4;
    localparam int FLAG_W        = 3;
    localparam int DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [ALU_RES_W-1:0] r;
        logic                 sf;
        logic                 zf;
        logic                 dzf;
    } entry_t;

endpackage

// File: rtl/sm_to_twos.sv
// Sign-magnitude to two's complement conversion for a 4-bit ALU result.
// Negative zero (4'b1000) maps to 0 because 0 - 0 wraps to 0.
module sm_to_twos
    import alu_pkg::*;
(
    input  logic [ALU_RES_W-1:0] sm,
    output logic [ALU_RES_W-1:0] twos
);

    logic [ALU_RES_W-1:0] mag;

    assign mag  = {1'b0, sm[ALU_RES_W-2:0]};
    assign twos = sm[ALU_RES_W-1] ? (ALU_RES_W'(0) - mag) : mag;

endmodule

// File: rtl/alu_result_fifo.sv
// Small FIFO buffering ALU results with their flags, plus sticky flag
// accumulation and a saturating count of results offered while full.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [ALU_RES_W-1:0]       in_r,
    input  logic                       in_sf,
    input  logic                       in_zf,
    input  logic                       in_dzf,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ALU_RES_W-1:0]       out_r,
    output logic                       out_sf,
    output logic                       out_zf,
    output logic                       out_dzf,
    output logic [ALU_RES_W-1:0]       out_twos,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sticky_sf,
    output logic                       sticky_zf,
    output logic                       sticky_dzf,
    input  logic                       clr_sticky,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic [FLAG_W-1:0]  sticky_reg;
    logic [FLAG_W-1:0]  sticky_next;
    logic [FLAG_W-1:0]  in_flags;
    logic [DROP_W-1:0]  drop_cnt_reg;
    logic               push;
    logic               pop;
    entry_t             head;
    entry_t             in_entry;

    assign in_ready  = (count_reg != CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign in_entry = '{r: in_r, sf: in_sf, zf: in_zf, dzf: in_dzf};
    assign in_flags = {in_sf, in_zf, in_dzf};

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end
    end

    // Set has priority over clear so a flagged push is never lost.
    generate
        for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_sticky
            assign sticky_next[gi] = (push && in_flags[gi]) || (sticky_reg[gi] && !clr_sticky);
        end
    endgenerate

    // Entry storage is never reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= in_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            sticky_reg   <= '0;
            drop_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg  <= count_next;
            sticky_reg <= sticky_next;
            if (in_valid && !in_ready && (drop_cnt_reg != '1)) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

    assign head = out_valid ? mem[rd_ptr_reg] : '0;

    sm_to_twos u_sm_to_twos (
        .sm   (head.r),
        .twos (out_twos)
    );

    assign out_r      = head.r;
    assign out_sf     = head.sf;
    assign out_zf     = head.zf;
    assign out_dzf    = head.dzf;
    assign count      = count_reg;
    assign sticky_sf  = sticky_reg[2];
    assign sticky_zf  = sticky_reg[1];
    assign sticky_dzf = sticky_reg[0];
    assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Randomized and directed bench for alu_result_fifo against a queue-based
// reference model of the buffer, sticky flags and drop counter.
module tb_alu_result_fifo;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] in_r = '0;
    logic       in_sf = 1'b0, in_zf = 1'b0, in_dzf = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_r;
    logic       out_sf, out_zf, out_dzf;
    logic [3:0] out_twos;
    logic [2:0] count;
    logic       sticky_sf, sticky_zf, sticky_dzf;
    logic       clr_sticky = 1'b0;
    logic [7:0] drop_cnt;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: entries stored as {r, sf, zf, dzf}.
    logic [6:0] model_q[$];
    logic [2:0] model_sticky = '0;
    int         model_drop   = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_r       (in_r),
        .in_sf      (in_sf),
        .in_zf      (in_zf),
        .in_dzf     (in_dzf),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_r      (out_r),
        .out_sf     (out_sf),
        .out_zf     (out_zf),
        .out_dzf    (out_dzf),
        .out_twos   (out_twos),
        .count      (count),
        .sticky_sf  (sticky_sf),
        .sticky_zf  (sticky_zf),
        .sticky_dzf (sticky_dzf),
        .clr_sticky (clr_sticky),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] expected_twos(input logic [3:0] r);
        int mag;
        mag = r[2:0];
        if (r[3]) return 4'((16 - mag) % 16);
        return 4'(mag);
    endfunction

    task automatic check_outputs();
        logic [6:0] h;
        logic [3:0] tw;
        h  = (model_q.size() != 0) ? model_q[0] : 7'd0;
        tw = (model_q.size() != 0) ? expected_twos(h[6:3]) : 4'd0;
        check("count", 32'(count), 32'(model_q.size()));
        check("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
        check("head", {21'd0, out_r, out_sf, out_zf, out_dzf, out_twos}, {21'd0, h, tw});
        check("sticky", 32'({sticky_sf, sticky_zf, sticky_dzf}), 32'(model_sticky));
        check("drop_cnt", 32'(drop_cnt), 32'(model_drop));
    endtask

    // One cycle: drive inputs, check current state, advance the model.
    task automatic apply(input logic iv, input logic [3:0] r, input logic [2:0] fl,
                         input logic ordy, input logic clr);
        bit full, push, pop;
        @(negedge clk);
        in_valid   = iv;
        in_r       = r;
        {in_sf, in_zf, in_dzf} = fl;
        out_ready  = ordy;
        clr_sticky = clr;
        #1;
        check_outputs();
        full = (model_q.size() == DEPTH);
        push = iv && !full;
        pop  = ordy && (model_q.size() != 0);
        if (iv && full && model_drop < 255) model_drop++;
        model_sticky = (clr ? 3'b000 : model_sticky) | (push ? fl : 3'b000);
        if (pop) void'(model_q.pop_front());
        if (push) model_q.push_back({r, fl});
        $display("cycle iv=%0b r=%b fl=%b ordy=%0b clr=%0b -> count=%0d", iv, r, fl, ordy, clr, model_q.size());
    endtask

    // Asynchronous reset: outputs must clear without any clock edge.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        clr_sticky = 1'b0;
        #1;
        model_q.delete();
        model_sticky = '0;
        model_drop   = 0;
        check_outputs();
        rst = 1'b0;
        $display("reset applied");
    endtask

    initial begin
        do_reset();

        // Single entry, then a signed entry with sticky set and cleared.
        apply(1, 4'b0011, 3'b000, 0, 0);
        apply(0, 4'b0000, 3'b000, 1, 0);
        apply(1, 4'b1101, 3'b100, 0, 0);
        apply(0, 4'b0000, 3'b000, 1, 0);
        apply(0, 4'b0000, 3'b000, 0, 1);
        apply(0, 4'b0000, 3'b000, 0, 0);

        // Fill, offer three more while full, then drain in order.
        for (int i = 0; i < 4; i++) apply(1, 4'(i + 9), 3'(i), 0, 0);
        for (int i = 0; i < 3; i++) apply(1, 4'b0111, 3'b111, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 4'b0000, 3'b000, 1, 0);

        // Hold occupancy at two with simultaneous push and pop.
        apply(1, 4'b0001, 3'b000, 0, 0);
        apply(1, 4'b1010, 3'b000, 0, 0);
        for (int i = 0; i < 6; i++) apply(1, 4'(i + 2), 3'b000, 1, 0);
        for (int i = 0; i < 3; i++) apply(0, 4'b0000, 3'b000, 1, 0);

        // Negative zero pushed with a coincident sticky clear.
        apply(1, 4'b1000, 3'b010, 0, 1);
        apply(0, 4'b0000, 3'b000, 1, 0);

        // Reset with three entries buffered and drop_cnt non-zero.
        for (int i = 0; i < 3; i++) apply(1, 4'(i + 4), 3'b001, 0, 0);
        apply(0, 4'b0000, 3'b000, 0, 0);
        do_reset();
        apply(1, 4'b1111, 3'b000, 0, 0);
        apply(0, 4'b0000, 3'b000, 1, 0);

        // Randomized traffic with shifting producer/consumer pressure.
        for (int i = 0; i < 400; i++) begin
            int thresh;
            thresh = (i < 100) ? 25 : (i < 200) ? 85 : 50;
            apply(logic'($urandom_range(0, 3) != 0), 4'($urandom), 3'($urandom),
                  logic'(($urandom % 100) < thresh), logic'($urandom_range(0, 9) == 0));
        end
        apply(0, 4'b0000, 3'b000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
